// File: rtl/perf_monitor.sv
// perf_monitor: retire-stage performance counters with end-of-program halt detection.
// Counts cycles, retired instructions, bubbles, flushes and per-class instructions
// in saturating counters. On retiring HALT_INSN it drains the pipe for DRAIN_CYC
// cycles and then freezes. Any counter is readable through a registered select port.
module perf_monitor #(
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] HALT_INSN = 32'h0000006F,
   parameter int unsigned DRAIN_CYC = 4,
   parameter int unsigned NUM_CNT   = 12
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_insn_vld,
   input  logic [31:0]      i_insn,
   input  logic             i_flush,
   input  logic [3:0]       i_sel,
   output logic [CNT_W-1:0] o_rdata,
   output logic             o_halted,
   output logic             o_done,
   output logic             o_sat
);

   localparam int unsigned      DRN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Counter map indices
   localparam int unsigned C_CYCLE  = 0;
   localparam int unsigned C_RETIRE = 1;
   localparam int unsigned C_BUBBLE = 2;
   localparam int unsigned C_LOAD   = 3;
   localparam int unsigned C_STORE  = 4;
   localparam int unsigned C_BRANCH = 5;
   localparam int unsigned C_JUMP   = 6;
   localparam int unsigned C_RALU   = 7;
   localparam int unsigned C_IALU   = 8;
   localparam int unsigned C_UPPER  = 9;
   localparam int unsigned C_FLUSH  = 10;
   localparam int unsigned C_OTHER  = 11;

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   state_e           state_q, state_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic [CNT_W-1:0] cnt_q [NUM_CNT];
   logic [CNT_W-1:0] cnt_d [NUM_CNT];
   logic [NUM_CNT-1:0] inc;
   logic             sat_q, sat_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] rdata_q, rdata_d;
   logic             counting;
   logic             halt_det;
   logic [6:0]       opcode;

   assign counting = (state_q == StRun) && i_en;
   assign halt_det = counting && i_insn_vld && (i_insn == HALT_INSN);
   assign opcode   = i_insn[6:0];

   // Event decode: which counters see an event this cycle
   always_comb begin
      inc           = '0;
      inc[C_CYCLE]  = counting;
      inc[C_RETIRE] = counting && i_insn_vld;
      inc[C_BUBBLE] = counting && !i_insn_vld;
      inc[C_FLUSH]  = counting && i_flush;
      if (counting && i_insn_vld) begin
         unique case (opcode)
            7'b0000011:             inc[C_LOAD]   = 1'b1;
            7'b0100011:             inc[C_STORE]  = 1'b1;
            7'b1100011:             inc[C_BRANCH] = 1'b1;
            7'b1101111, 7'b1100111: inc[C_JUMP]   = 1'b1;
            7'b0110011:             inc[C_RALU]   = 1'b1;
            7'b0010011:             inc[C_IALU]   = 1'b1;
            7'b0110111, 7'b0010111: inc[C_UPPER]  = 1'b1;
            default:                inc[C_OTHER]  = 1'b1;
         endcase
      end
   end

   // Saturating counter next-state and sticky saturation flag
   always_comb begin
      sat_d = sat_q;
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (i_clr) begin
            cnt_d[i] = '0;
         end else if (inc[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
         if (cnt_d[i] == CNT_MAX) begin
            sat_d = 1'b1;
         end
      end
      if (i_clr) begin
         sat_d = 1'b0;
      end
   end

   // FSM next-state: RUN -> DRAIN on halt insn, DRAIN counts down to HALTED
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      if (i_clr) begin
         state_d = StRun;
      end else begin
         unique case (state_q)
            StRun: begin
               if (halt_det) begin
                  state_d = StDrain;
                  drain_d = DRN_LOAD;
               end
            end
            StDrain: begin
               if (drain_q == '0) begin
                  state_d = StHalted;
               end else begin
                  drain_d = drain_q - DRN_W'(1);
               end
            end
            StHalted: ;
            default: state_d = StRun;
         endcase
      end
   end

   // FSM outputs: halted level and done pulse on the DRAIN->HALTED transition
   always_comb begin
      o_halted = (state_q == StHalted);
      done_d   = (state_q == StDrain) && (drain_q == '0) && !i_clr;
   end

   // Readout mux; unmapped selects read as zero
   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (i_sel == 4'(i)) begin
            rdata_d = cnt_q[i];
         end
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StRun;
         drain_q <= '0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign o_rdata = rdata_q;
   assign o_done  = done_q;
   assign o_sat   = sat_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: a 32-bit and a 4-bit instance share stimulus.
// The reference model keeps unbounded event counts and saturates only when
// forming the expected readout, so wrap/hold behaviour is checked independently.
module tb_perf_monitor;

   localparam int          DRAIN_CYC = 4;
   localparam logic [31:0] HALT      = 32'h0000006F;
   localparam logic [31:0] ADDI      = 32'h00100093;
   localparam logic [31:0] LW        = 32'h0002A303;

   logic        clk = 1'b0;
   logic        rst = 1'b1, en = 1'b0, clr = 1'b0, vld = 1'b0, flush = 1'b0;
   logic [31:0] insn = '0;
   logic [3:0]  sel = '0;
   logic [31:0] rdata;
   logic [3:0]  rdata4;
   logic        halted, done, sat, halted4, done4, sat4;

   always #5 clk = ~clk;

   perf_monitor u_dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_insn_vld(vld), .i_insn(insn),
      .i_flush(flush), .i_sel(sel), .o_rdata(rdata), .o_halted(halted), .o_done(done),
      .o_sat(sat)
   );

   perf_monitor #(.CNT_W(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_insn_vld(vld), .i_insn(insn),
      .i_flush(flush), .i_sel(sel), .o_rdata(rdata4), .o_halted(halted4), .o_done(done4),
      .o_sat(sat4)
   );

   typedef struct {
      int          due;
      logic [31:0] rd;
      logic [3:0]  rd4;
      logic        halted;
      logic        done;
      logic        sat;
      logic        sat4;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   edge_cnt = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: raw event counts plus a RUN/DRAIN/HALTED mode
   longint unsigned m_cnt[12];
   int              m_mode = 0;   // 0 run, 1 drain, 2 halted
   int              m_age = 0;    // edges spent in drain
   bit              m_done = 1'b0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic longint unsigned clip(longint unsigned v, int w);
      longint unsigned lim = (64'd1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   function automatic bit any_sat(int w);
      longint unsigned lim = (64'd1 << w) - 1;
      for (int i = 0; i < 12; i++) if (m_cnt[i] >= lim) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int insn_class(logic [31:0] x);
      case (x[6:0])
         7'h03: return 3;
         7'h23: return 4;
         7'h63: return 5;
         7'h6F, 7'h67: return 6;
         7'h33: return 7;
         7'h13: return 8;
         7'h37, 7'h17: return 9;
         default: return 11;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
      end
   endtask

   // Apply one cycle of stimulus, record the expected response, advance the model
   task automatic step(input bit r, input bit c, input bit e, input bit v, input bit f,
                       input logic [31:0] ins, input logic [3:0] s, input string tag);
      exp_t x;
      rst = r; clr = c; en = e; vld = v; flush = f; insn = ins; sel = s;
      x.due = edge_cnt + 1;
      x.tag = tag;
      x.rd  = (r || s >= 12) ? 32'h0 : 32'(clip(m_cnt[s], 32));
      x.rd4 = (r || s >= 12) ? 4'h0 : 4'(clip(m_cnt[s], 4));
      if (r || c) begin
         for (int i = 0; i < 12; i++) m_cnt[i] = 0;
         m_mode = 0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_mode == 0) begin
            if (e) begin
               m_cnt[0]++;
               if (v) begin
                  m_cnt[1]++;
                  m_cnt[insn_class(ins)]++;
               end else begin
                  m_cnt[2]++;
               end
               if (f) m_cnt[10]++;
               if (v && ins == HALT) begin
                  m_mode = 1;
                  m_age  = 0;
               end
            end
         end else if (m_mode == 1) begin
            m_age++;
            if (m_age == DRAIN_CYC) begin
               m_mode = 2;
               m_done = 1'b1;
            end
         end
      end
      x.halted = (m_mode == 2);
      x.done   = m_done;
      x.sat    = any_sat(32);
      x.sat4   = any_sat(4);
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare outputs once the recorded edge has happened
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
         e = sb.pop_front();
         chk({e.tag, ".rdata"}, rdata, e.rd);
         chk({e.tag, ".rdata4"}, {28'h0, rdata4}, {28'h0, e.rd4});
         chk({e.tag, ".halted"}, {31'h0, halted}, {31'h0, e.halted});
         chk({e.tag, ".halted4"}, {31'h0, halted4}, {31'h0, e.halted});
         chk({e.tag, ".done"}, {31'h0, done}, {31'h0, e.done});
         chk({e.tag, ".done4"}, {31'h0, done4}, {31'h0, e.done});
         chk({e.tag, ".sat"}, {31'h0, sat}, {31'h0, e.sat});
         chk({e.tag, ".sat4"}, {31'h0, sat4}, {31'h0, e.sat4});
      end
   end

   logic [6:0] ops[10] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17, 7'h7F};

   initial begin
      logic [31:0] ri;
      for (int i = 0; i < 12; i++) m_cnt[i] = 0;
      step(1, 0, 0, 0, 0, '0, 4'd0, "reset");
      step(1, 0, 0, 0, 0, '0, 4'd1, "reset");
      step(0, 0, 0, 0, 0, '0, 4'd0, "reset_idle");
      // 1: ten retired addi
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0, ADDI, 4'(i % 3), "addi");
      foreach (ops[i]) if (i < 4) step(0, 0, 0, 0, 0, '0, (i == 2) ? 4'd8 : 4'(i), "addi_rd");
      step(0, 0, 0, 0, 0, '0, 4'd2, "addi_rd");
      // 2: alternating bubble / lw with two flushes
      for (int i = 0; i < 8; i++) step(0, 0, 1, i[0], (i == 1 || i == 4), LW, 4'd3, "lw");
      step(0, 0, 0, 0, 0, '0, 4'd2, "lw_rd");
      step(0, 0, 0, 0, 0, '0, 4'd3, "lw_rd");
      step(0, 0, 0, 0, 0, '0, 4'd10, "lw_rd");
      // 3: halt, drain, frozen counters, then clear
      step(0, 0, 1, 1, 0, HALT, 4'd6, "halt");
      for (int i = 0; i < 10; i++)
         step(0, 0, 1, 1'($urandom), 1'($urandom), ADDI, 4'($urandom_range(0, 11)), "halted");
      step(0, 1, 1, 0, 0, '0, 4'd0, "clr");
      step(0, 0, 0, 0, 0, '0, 4'd0, "clr_rd");
      // 4: saturate the 4-bit instance
      for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0, ADDI, 4'(i % 2), "sat");
      step(0, 0, 0, 0, 0, '0, 4'd8, "sat_rd");
      // 5: clear wins over a same-cycle event; unmapped selects read zero
      step(0, 1, 1, 1, 1, ADDI, 4'd1, "clr_evt");
      for (int i = 12; i < 16; i++) step(0, 0, 1, 1, 0, ADDI, 4'(i), "sel_hi");
      step(0, 0, 0, 0, 0, '0, 4'd0, "sel_hi");
      // 6: reset mid-drain aborts without a done pulse
      step(0, 0, 1, 1, 0, HALT, 4'd0, "halt2");
      step(0, 0, 0, 0, 0, '0, 4'd0, "drain");
      step(0, 0, 0, 0, 0, '0, 4'd0, "drain");
      step(1, 0, 0, 0, 0, '0, 4'd0, "rst_drain");
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, '0, 4'(i), "post_rst");
      // Random traffic
      for (int n = 0; n < 600; n++) begin
         ri = $urandom;
         if ($urandom_range(0, 15) == 0) ri = HALT;
         else ri[6:0] = (ops[ri[10:7] % 10] == 7'h7F) ? 7'($urandom) : ops[ri[10:7] % 10];
         step(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), ri, 4'($urandom), "rand");
      end
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain_queue: %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
